// File: rtl/pipelined_memory.sv
// Single-port word memory behind a one-outstanding-request IDLE/WAIT/RESP handshake.
// Optional macro MEM_BOUNDS_CHECK_EN: out-of-range addresses fault instead of wrapping.
module pipelined_memory #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 2048,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [31:0]        req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
  input  logic [WIDTH/8-1:0] req_byte_en,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [WIDTH-1:0]   resp_rdata,
  output logic               resp_error,
  output logic [1:0]         o_dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = WIDTH / 8;
  localparam int CW = 4;

  // Handshakes: a request transfers on a rising edge with req_valid && req_ready
  // (and rst low); a response transfers on a rising edge with resp_valid && resp_ready.
  // Once raised, resp_valid holds with stable payload until its transfer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [WIDTH-1:0]  r_rdata;
  logic              r_error;
  logic              w_accept;
  logic              w_oob;
  logic [AW-1:0]     w_idx;
  logic              w_unused_addr;

  assign w_idx = req_addr[AW-1:0];

`ifdef MEM_BOUNDS_CHECK_EN
  assign w_oob         = |req_addr[31:AW];
  assign w_unused_addr = 1'b0;
`else
  // Upper address bits are dropped so addresses wrap modulo DEPTH.
  assign w_oob         = 1'b0;
  assign w_unused_addr = ^req_addr[31:AW];
`endif

  assign w_accept    = req_valid & req_ready & ~rst;
  assign resp_rdata  = r_rdata;
  assign resp_error  = r_error;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = CW'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = RESP;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Memory is never reset; a committed write survives a later reset.
  always_ff @(posedge clk) begin
    if (w_accept && req_write && !w_oob) begin
      for (int b = 0; b < NB; b++) begin
        if (req_byte_en[b]) begin
          r_mem[w_idx][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read data is captured at acceptance so the response is stable through backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
      r_error <= 1'b0;
    end else if (w_accept) begin
      r_error <= w_oob;
      r_rdata <= (req_write || w_oob) ? '0 : r_mem[w_idx];
    end
  end

endmodule

// File: tb/tb_pipelined_memory.sv
// Scoreboard bench for pipelined_memory: randomized and directed requests checked
// against an array model of memory, with latency and backpressure-stability checks.
module tb_pipelined_memory;
  parameter int LAT = 2;
  localparam int W  = 32;
  localparam int D  = 2048;
  localparam int NB = W / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [31:0]   req_addr = '0;
  logic [W-1:0]  req_wdata = '0;
  logic [NB-1:0] req_byte_en = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [W-1:0]  resp_rdata;
  logic          resp_error;
  logic [1:0]    dbg_state;

  pipelined_memory #(.WIDTH(W), .DEPTH(D), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_byte_en(req_byte_en),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int rr_mode = 0;     // 0: always ready, 1: random, 2: driven by the test
  int last_acc = 0;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic         err_q[$];
  int           cyc_q[$];
  logic [W-1:0] m_mem [D];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timed out (t=%0t)", nm, $time);
  endtask

  // resp_ready changes just after the rising edge so it is stable when sampled.
  always @(posedge clk) begin
    #1;
    if (rr_mode == 0) resp_ready = 1'b1;
    else if (rr_mode == 1) resp_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver ----------------
  task automatic issue(input logic w, input logic [31:0] a, input logic [W-1:0] d,
                       input logic [NB-1:0] be);
    int n;
    int idx;
    logic oob;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_byte_en = be;
    while (!(req_ready === 1'b1 && rst === 1'b0)) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        fail_now("req_accept");
        req_valid = 1'b0;
        return;
      end
    end
    idx = int'(a % D);
`ifdef MEM_BOUNDS_CHECK_EN
    oob = (a >= D);
`else
    oob = 1'b0;
`endif
    if (oob) begin
      exp_q.push_back('0); err_q.push_back(1'b1);
    end else if (w) begin
      for (int b = 0; b < NB; b++)
        if (be[b]) m_mem[idx][8*b +: 8] = d[8*b +: 8];
      exp_q.push_back('0); err_q.push_back(1'b0);
    end else begin
      exp_q.push_back(m_mem[idx]); err_q.push_back(1'b0);
    end
    last_acc = cyc + 1;
    cyc_q.push_back(cyc + 1 + LAT);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_q.size() == 0 && resp_valid === 1'b0 && req_ready === 1'b1) && n < 300);
    if (n >= 300) fail_now("drain");
  endtask

  // ---------------- monitor ----------------
  logic         m_lv = 1'b0;
  logic         m_lh = 1'b0;
  logic [W-1:0] m_ld = '0;
  logic         m_le = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        if (m_lv && !m_lh) begin
          chk("hold_rdata", resp_rdata, m_ld);
          chk("hold_error", W'(resp_error), W'(m_le));
        end else if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_resp actual=resp_valid=1 expected=resp_valid=0 (t=%0t)", $time);
        end else begin
          chk("resp_rdata", resp_rdata, exp_q.pop_front());
          chk("resp_error", W'(resp_error), W'(err_q.pop_front()));
          chk("resp_latency", W'(cyc), W'(cyc_q.pop_front()));
        end
      end
      m_lv = resp_valid;
      m_lh = resp_valid && resp_ready;
      m_ld = resp_rdata;
      m_le = resp_error;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [31:0] pool [8];
  int acc [3];
  int n;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_req_ready", W'(req_ready), W'(1));
    chk("rst_resp_valid", W'(resp_valid), W'(0));
    chk("rst_rdata", resp_rdata, '0);
    chk("rst_error", W'(resp_error), W'(0));
    rst = 1'b0;

    // Basic write then read.
    issue(1'b1, 32'd5, 32'hDEADBEEF, 4'hF);
    issue(1'b0, 32'd5, '0, '0);

    // Byte enables, including an all-zero enable that must write nothing.
    issue(1'b1, 32'd7, 32'h11223344, 4'hF);
    issue(1'b1, 32'd7, 32'hAABBCCDD, 4'h5);
    issue(1'b0, 32'd7, '0, '0);
    issue(1'b1, 32'd7, 32'hFFFFFFFF, 4'h0);
    issue(1'b0, 32'd7, '0, '0);
    wait_drain();

    // Backpressure: hold resp_ready low while the response waits.
    rr_mode = 2;
    @(posedge clk); #1 resp_ready = 1'b0;
    issue(1'b0, 32'd5, '0, '0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (resp_valid !== 1'b1 && n < 50);
    if (n >= 50) fail_now("bp_resp_valid");
    for (int i = 0; i < 4; i++) begin
      chk("bp_req_ready_low", W'(req_ready), W'(0));
      if (i < 3) @(negedge clk);
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_at_release", W'(resp_valid), W'(1));
    @(negedge clk);
    chk("bp_req_ready_after", W'(req_ready), W'(1));
    chk("bp_valid_after", W'(resp_valid), W'(0));
    rr_mode = 0;

    // Reset while a read waits; a committed write survives.
    issue(1'b1, 32'd9, 32'hA5A55A5A, 4'hF);
    wait_drain();
    issue(1'b0, 32'd5, '0, '0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete(); err_q.delete(); cyc_q.delete();
    @(negedge clk);
    chk("midrst_req_ready", W'(req_ready), W'(1));
    chk("midrst_resp_valid", W'(resp_valid), W'(0));
    // A request offered during reset must not be taken.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd9;
    req_wdata = 32'h0BADF00D; req_byte_en = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    chk("postrst_req_ready", W'(req_ready), W'(1));
    issue(1'b0, 32'd9, '0, '0);
    wait_drain();

    // Out-of-range address: faults with the bounds check, wraps without it.
    issue(1'b1, 32'd0, 32'h12345678, 4'hF);
    issue(1'b1, 32'(D), 32'hCAFEF00D, 4'hF);
    issue(1'b0, 32'd0, '0, '0);
    wait_drain();

    // Randomized traffic over a preloaded address pool with random backpressure.
    rr_mode = 1;
    for (int i = 0; i < 8; i++) begin
      pool[i] = $urandom_range(0, D - 1);
      issue(1'b1, pool[i], $urandom, 4'hF);
    end
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) a = a + D * $urandom_range(1, 7);
      if ($urandom_range(0, 1) == 1) issue(1'b1, a, $urandom, 4'($urandom_range(0, 15)));
      else issue(1'b0, a, '0, '0);
    end
    rr_mode = 0;
    wait_drain();

    // Back-to-back reads: one acceptance every LAT+2 cycles.
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, pool[i], '0, '0);
      acc[i] = last_acc;
    end
    chk("b2b_spacing_01", W'(acc[1] - acc[0]), W'(LAT + 2));
    chk("b2b_spacing_12", W'(acc[2] - acc[1]), W'(LAT + 2));
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_memory.md
PIPELINED_MEMORY -- requirements
Module: pipelined_memory

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits, multiple of 8.
REQ-002 Parameter DEPTH, default 2048: number of words, power of two, at least 2.
REQ-003 Parameter LATENCY, default 2: cycles from request acceptance to response, range 1..15.
REQ-004 Ports SHALL be, in order: clk in 1 (single clock; all logic on rising edge); rst in 1 (synchronous, active-high reset).
REQ-005 req_valid in 1 (request present); req_ready out 1 (block can accept); req_write in 1 (1 = write, 0 = read); req_addr in 32 (word address).
REQ-006 req_wdata in WIDTH (write data); req_byte_en in WIDTH/8 (per-byte write enable, bit i covers bits 8i+7..8i).
REQ-007 resp_valid out 1 (response present); resp_ready in 1 (consumer accepts); resp_rdata out WIDTH (read data); resp_error out 1 (request faulted).

Function
REQ-008 States SHALL be IDLE, WAIT and RESP, with one outstanding request at most.
REQ-009 req_ready SHALL be 1 only in IDLE, combinationally from state.
REQ-010 Acceptance: req_valid=1 and req_ready=1 at a rising edge; on that edge the state moves to WAIT and the latency counter loads LATENCY-1.
REQ-011 An accepted write SHALL update, on the acceptance edge, only the bytes whose req_byte_en bit is 1; all-zero byte_en writes nothing.
REQ-012 An accepted read SHALL capture the addressed word on the acceptance edge into the response register.
REQ-013 In WAIT, the counter decrements each edge; when it is 0 at an edge the state moves to RESP. For LATENCY=1, WAIT lasts one cycle.
REQ-014 resp_valid SHALL be 1 only in RESP and SHALL remain 1 with stable resp_rdata and resp_error until resp_ready=1 at an edge; that edge returns the state to IDLE.
REQ-015 resp_ready is ignored outside RESP. A new request is accepted no earlier than the cycle after the response handshake, so back-to-back throughput is one request per LATENCY+2 cycles.
REQ-016 A write response SHALL present resp_rdata = 0.
REQ-017 A read of a word written by the immediately preceding request SHALL return the new data.
REQ-018 Addresses use req_addr[log2(DEPTH)-1:0]. Upper-bit handling is defined in Configuration.

Reset
REQ-019 When rst=1 at an edge: state becomes IDLE, counter becomes 0, and resp_rdata and resp_error become 0. After the edge, req_ready=1 and resp_valid=0.
REQ-020 A reset in WAIT or RESP SHALL discard the pending response. A write already committed on its acceptance edge stays committed.
REQ-021 A request presented with rst=1 SHALL NOT be accepted and SHALL NOT modify memory.
REQ-022 Reset SHALL NOT clear memory contents; memory is uninitialised at power-up.

Configuration
REQ-023 Macro MEM_BOUNDS_CHECK_EN, when defined: a request with any req_addr bit at or above log2(DEPTH) set SHALL be accepted normally, SHALL NOT access memory, and SHALL respond after LATENCY with resp_error=1 and resp_rdata=0.
REQ-024 When MEM_BOUNDS_CHECK_EN is undefined: upper address bits are ignored (address wraps modulo DEPTH), and resp_error is tied to 0.

Verification
REQ-025 Reset, then write 0xDEADBEEF to address 5 with byte_en=0xF, then read address 5 -> resp_rdata=0xDEADBEEF with resp_valid rising LATENCY edges after acceptance; resp_error=0.
REQ-026 Byte enables: preload 0x11223344 at address 7, write 0xAABBCCDD with byte_en=0x5, then read address 7 -> 0x11BB33DD.
REQ-027 Backpressure: read issued, resp_ready held 0 for 4 cycles after resp_valid -> resp_valid and resp_rdata stable for all 4 cycles, req_ready=0 throughout; req_ready=1 the cycle after the handshake.
REQ-028 Reset mid-operation: accept a read, assert rst in WAIT -> resp_valid is never asserted for that read, and req_ready=1 after the reset edge. A write accepted before the reset reads back intact afterwards.
REQ-029 With MEM_BOUNDS_CHECK_EN defined and DEPTH=2048: write to address 2048, then read address 0 -> the write responds with resp_error=1, and address 0 is unchanged. Without the macro, the same write lands in address 0.
REQ-030 LATENCY=1 build: read response is asserted exactly one edge after acceptance; issue 3 reads back-to-back with resp_ready=1 -> 3 responses, each one request per 3 cycles.
